// File: rtl/timer_scheduler_pkg.sv
// Shared types and helpers for the timer scheduler slice.
//   state_t   : scheduler FSM encoding (IDLE, COUNT, DONE)
//   DEF_NREQ  : default number of requesters
//   DEF_W     : default delay width in ticks
//   idx_w()   : width of a requester index for a given requester count
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 10;

  // Index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_scheduler_if.sv
// Requester-side bundle of the timer scheduler.
//   req    : per-requester request, held high until the matching ack pulse
//   delay  : packed per-requester delay, delay[i*W +: W] belongs to requester i
//   ack    : one-cycle pulse, request accepted and its delay latched
//   done   : one-cycle pulse, the granted delay has expired
//   busy   : a delay is currently owned
//   owner  : index of the current or last granted requester
//   cancel : abort of the owner's countdown (TIMER_SCHED_CANCEL_EN builds only)
// Handshake: a requester raises req[i] with delay[i] stable and keeps both until
// it sees ack[i]; the delay is captured on the edge that produces ack[i]. done[i]
// later completes the transaction. No back-pressure exists on done.
// Modports: master = game-logic requester side, slave = scheduler side.
interface timer_scheduler_if #(
  parameter int NREQ = timer_sched_pkg::DEF_NREQ,
  parameter int W    = timer_sched_pkg::DEF_W
);
  localparam int IW = timer_sched_pkg::idx_w(NREQ);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] delay;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [IW-1:0]     owner;
`ifdef TIMER_SCHED_CANCEL_EN
  logic [NREQ-1:0]   cancel;

  modport master (output req, delay, cancel, input ack, done, busy, owner);
  modport slave  (input req, delay, cancel, output ack, done, busy, owner);
`else
  modport master (output req, delay, input ack, done, busy, owner);
  modport slave  (input req, delay, output ack, done, busy, owner);
`endif

endinterface

// File: rtl/timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   last  : index of the previously served requester
//   grant : first set request scanning last+1, last+2, ... modulo NREQ
//   valid : at least one request is set
// The previously served requester is scanned last, so it only wins again when
// nobody else is asking.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]        req,
  input  logic [idx_w(NREQ)-1:0] last,
  output logic [idx_w(NREQ)-1:0] grant,
  output logic                   valid
);
  localparam int IW = idx_w(NREQ);

  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shared delay countdown engine for NREQ game-logic requesters.
// Arbitrates pending requests round-robin, latches the winner's delay, counts it
// down on tick strobes and pulses done to that requester. One wait in flight.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   tick       : count-enable strobe, only honoured in COUNT
//   bus        : timer_scheduler_if.slave (req/delay in, ack/done/busy/owner out)
//   dbg_state  : current FSM state for observation
// Build option: define TIMER_SCHED_CANCEL_EN to enable bus.cancel, which lets
// the owner abort its countdown without a done pulse.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  timer_scheduler_if.slave        bus,
  output state_t                  dbg_state
);
  localparam int IW = idx_w(NREQ);

  state_t          state;
  logic [W-1:0]    count;
  logic [IW-1:0]   last;
  logic [IW-1:0]   owner_r;
  logic [NREQ-1:0] ack_r;
  logic [NREQ-1:0] done_r;
  logic            busy_r;

  logic [IW-1:0]   grant;
  logic            grant_valid;
  logic            cancel_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req),
    .last  (last),
    .grant (grant),
    .valid (grant_valid)
  );

`ifdef TIMER_SCHED_CANCEL_EN
  assign cancel_hit = bus.cancel[owner_r];
`else
  assign cancel_hit = 1'b0;
`endif

  // done is raised on the edge entering DONE so it is high exactly while the
  // FSM sits in DONE; busy is registered to cover COUNT and DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      last    <= IW'(NREQ - 1);
      owner_r <= '0;
      ack_r   <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      ack_r  <= '0;
      done_r <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            count        <= bus.delay[grant*W +: W];
            owner_r      <= grant;
            ack_r[grant] <= 1'b1;
            busy_r       <= 1'b1;
            state        <= COUNT;
          end
        end
        COUNT: begin
          // Cancel wins over a simultaneous expiring tick.
          if (cancel_hit) begin
            last   <= owner_r;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (tick) begin
            if (count == '0) begin
              done_r[owner_r] <= 1'b1;
              state           <= DONE;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        DONE: begin
          last   <= owner_r;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack   = ack_r;
  assign bus.done  = done_r;
  assign bus.busy  = busy_r;
  assign bus.owner = owner_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_timer_scheduler.sv
module tb_timer_scheduler;
  import timer_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 10;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  logic   tick;
  state_t dbg_state;

  always #5 clk = ~clk;

  timer_scheduler_if #(.NREQ(NREQ), .W(W)) bus();

  timer_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_ack_q[$];
  logic [7:0] exp_done_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic scoreboard();
    logic [7:0] e;
    if (bus.ack != '0) begin
      chk("ack_done_excl", int'(bus.done != '0), 0);
      if (exp_ack_q.size() == 0) chk("ack_unexpected", idx_of(bus.ack), -1);
      else begin
        e = exp_ack_q.pop_front();
        chk("ack_onehot", int'($onehot(bus.ack)), 1);
        chk("ack_idx", idx_of(bus.ack), int'(e));
      end
    end
    if (bus.done != '0) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", idx_of(bus.done), -1);
      else begin
        e = exp_done_q.pop_front();
        chk("done_onehot", int'($onehot(bus.done)), 1);
        chk("done_idx", idx_of(bus.done), int'(e));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    scoreboard();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    tick = 1'b0;
    exp_ack_q.delete();
    exp_done_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_delays(input int g, input int d);
    for (int i = 0; i < NREQ; i++)
      bus.delay[i*W +: W] = (i == g) ? W'(d) : W'($urandom_range(0, 1023));
  endtask

  task automatic wait_ack(output bit ok);
    int c;
    ok = 1'b0;
    c = 0;
    while (!ok && c < 10) begin
      step();
      if (bus.ack != '0) ok = 1'b1;
      c++;
    end
  endtask

  // Issue one tick every tp cycles until done; ticks counts ticks sampled.
  task automatic count_down(input int tp, output int ticks, output bit got, output bit busy_ok);
    int c;
    ticks = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    c = 0;
    while (!got && c < 300) begin
      tick = ((c % tp) == tp - 1);
      if (tick) ticks++;
      step();
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done != '0) got = 1'b1;
      c++;
    end
    tick = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int dly;
    int tp;
    int exp_g;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok, got, busy_ok;
    int ticks, acks, dones, c;

    reset = 1'b1;
    tick = 1'b0;
    bus.req = '0;
    bus.delay = '0;
`ifdef TIMER_SCHED_CANCEL_EN
    bus.cancel = '0;
`endif
    #2;
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_state", int'(dbg_state), int'(IDLE));
    do_reset();

    // ---------------- table-driven vectors (from reset, last = 3) ----------------
    vecs[0] = '{4'b0010, 3, 1, 1};
    vecs[1] = '{4'b1111, 1, 1, 2};
    vecs[2] = '{4'b1001, 0, 2, 3};
    vecs[3] = '{4'b1010, 2, 3, 1};
    vecs[4] = '{4'b0001, 5, 1, 0};
    vecs[5] = '{4'b0110, 7, 2, 1};
    vecs[6] = '{4'b0101, 4, 1, 2};
    vecs[7] = '{4'b1000, 0, 1, 3};

    for (int v = 0; v < 8; v++) begin
      set_delays(vecs[v].exp_g, vecs[v].dly);
      exp_ack_q.push_back(8'(vecs[v].exp_g));
      exp_done_q.push_back(8'(vecs[v].exp_g));
      bus.req = vecs[v].req;
      wait_ack(ok);
      chk($sformatf("v%0d_ack_seen", v), int'(ok), 1);
      bus.req = '0;
      chk($sformatf("v%0d_owner", v), int'(bus.owner), vecs[v].exp_g);
      chk($sformatf("v%0d_state_count", v), int'(dbg_state), int'(COUNT));
      count_down(vecs[v].tp, ticks, got, busy_ok);
      chk($sformatf("v%0d_done_seen", v), int'(got), 1);
      chk($sformatf("v%0d_ticks", v), ticks, vecs[v].dly + 1);
      chk($sformatf("v%0d_busy_held", v), int'(busy_ok), 1);
      step();
      chk($sformatf("v%0d_busy_low", v), int'(bus.busy), 0);
      chk($sformatf("v%0d_owner_kept", v), int'(bus.owner), vecs[v].exp_g);
    end

    // ---------------- round-robin with req held ----------------
    do_reset();
    for (int i = 0; i < NREQ; i++) bus.delay[i*W +: W] = W'(1);
    foreach (vecs[k]) if (k < 5) begin
      exp_ack_q.push_back(8'(k % NREQ));
      exp_done_q.push_back(8'(k % NREQ));
    end
    bus.req = '1;
    tick = 1'b1;
    acks = 0;
    dones = 0;
    c = 0;
    while (dones < 5 && c < 100) begin
      step();
      if (bus.ack != '0) begin
        acks++;
        if (acks == 5) bus.req = '0;
      end
      if (bus.done != '0) dones++;
      c++;
    end
    tick = 1'b0;
    chk("rr_acks", acks, 5);
    chk("rr_dones", dones, 5);
    step();
    step();
    chk("rr_no_more_ack", int'(bus.busy), 0);

    // ---------------- zero delay ----------------
    do_reset();
    set_delays(0, 0);
    exp_ack_q.push_back(8'd0);
    exp_done_q.push_back(8'd0);
    bus.req = 4'b0001;
    wait_ack(ok);
    chk("z_ack_seen", int'(ok), 1);
    bus.req = '0;
    got = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.done != '0) got = 1'b1;
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk("z_no_early_done", int'(got), 0);
    chk("z_busy_idle_wait", int'(busy_ok), 1);
    chk("z_still_count", int'(dbg_state), int'(COUNT));
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("z_done0", int'(bus.done), 1);
    chk("z_state_done", int'(dbg_state), int'(DONE));
    step();
    chk("z_state_idle", int'(dbg_state), int'(IDLE));
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    chk("z_idle_tick_ignored", int'(bus.busy), 0);

    // ---------------- reset mid-count ----------------
    set_delays(2, 9);
    exp_ack_q.push_back(8'd2);
    exp_done_q.push_back(8'd2);
    bus.req = 4'b0100;
    wait_ack(ok);
    chk("r_ack_seen", int'(ok), 1);
    bus.req = '0;
    tick = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tick = 1'b0;
    chk("r_owner_before", int'(bus.owner), 2);
    chk("r_busy_before", int'(bus.busy), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("r_async_busy", int'(bus.busy), 0);
    chk("r_async_owner", int'(bus.owner), 0);
    chk("r_async_state", int'(dbg_state), int'(IDLE));
    chk("r_async_done", int'(bus.done), 0);
    exp_done_q.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.delay[i*W +: W] = W'(1);
    exp_ack_q.push_back(8'd0);
    exp_done_q.push_back(8'd0);
    bus.req = '1;
    wait_ack(ok);
    chk("r_regrant_seen", int'(ok), 1);
    bus.req = '0;
    chk("r_regrant_owner", int'(bus.owner), 0);
    count_down(1, ticks, got, busy_ok);
    chk("r_regrant_ticks", ticks, 2);

`ifdef TIMER_SCHED_CANCEL_EN
    // ---------------- cancel ----------------
    step();
    set_delays(1, 0);
    exp_ack_q.push_back(8'd1);
    bus.req = 4'b0010;
    wait_ack(ok);
    chk("c_ack_seen", int'(ok), 1);
    bus.req = '0;
    bus.cancel = 4'b0001;
    step();
    chk("c_nonowner_ignored", int'(dbg_state), int'(COUNT));
    bus.cancel = 4'b0010;
    tick = 1'b1;
    step();
    bus.cancel = '0;
    tick = 1'b0;
    chk("c_state_idle", int'(dbg_state), int'(IDLE));
    chk("c_busy_low", int'(bus.busy), 0);
    chk("c_no_done", int'(bus.done), 0);
    step();
    chk("c_no_late_done", int'(bus.done), 0);
    set_delays(0, 0);
    exp_ack_q.push_back(8'd0);
    exp_done_q.push_back(8'd0);
    bus.req = 4'b0011;
    wait_ack(ok);
    bus.req = '0;
    chk("c_rotation_owner", int'(bus.owner), 0);
    count_down(1, ticks, got, busy_ok);
    chk("c_after_ticks", ticks, 1);
`endif

    step();
    step();
    chk("ack_q_drained", exp_ack_q.size(), 0);
    chk("done_q_drained", exp_done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
